// File: rtl/effect_scheduler.sv
// Time-shares one limiter-style effect unit across four voice channels and
// mixes the processed channels into one saturated 12-bit sample per ready strobe.
module effect_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ready,
    input  logic [NUM_CH*12-1:0]   ch_samples,
    input  logic [NUM_CH-1:0]      ch_enable,
    input  logic [NUM_CH*2-1:0]    ch_amount,
    input  logic                   clear_flags,
    output logic                   fx_start,
    output logic [11:0]            fx_sample,
    output logic [1:0]             fx_amount,
    output logic                   fx_enable,
    input  logic [11:0]            fx_result,
    input  logic                   fx_done,
    output logic [11:0]            mixed_sample,
    output logic                   mix_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        MIX   = 2'd3
    } state_t;

    state_t             state_q;
    logic [11:0]        samples_q [NUM_CH];
    logic [1:0]         amounts_q [NUM_CH];
    logic [NUM_CH-1:0]  enable_q;
    logic signed [13:0] acc_q;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic               fx_start_q;
    logic [11:0]        fx_sample_q;
    logic [1:0]         fx_amount_q;
    logic               fx_enable_q;
    logic [11:0]        mixed_q;
    logic               mix_valid_q;
    logic               busy_q;
    logic               timeout_err_q;
    logic               overrun_q;

    logic               accept_d;
    logic               last_ch_d;
    logic [CW-1:0]      cnt_d;
    logic               expire_d;
    logic signed [13:0] acc_d;
    logic               set_timeout_d;
    logic               set_overrun_d;

    // Saturate the 14-bit accumulator into the 12-bit signed output range.
    function automatic logic [11:0] clamp12(input logic signed [13:0] a);
        logic [11:0] r;
        if (a > 14'sd2047) begin
            r = 12'h7FF;
        end else if (a < -14'sd2048) begin
            r = 12'h800;
        end else begin
            r = a[11:0];
        end
        return r;
    endfunction

    // Done is ignored on the edge that also carries the start pulse: a level held
    // high from the previous transaction must not be taken as this one's result.
    always_comb begin
        accept_d      = fx_done && !fx_start_q;
        last_ch_d     = (idx_q == IW'(NUM_CH - 1));
        cnt_d         = cnt_q + CW'(1);
        expire_d      = (cnt_d == CW'(TIMEOUT));
        acc_d         = acc_q + $signed({{2{fx_result[11]}}, fx_result});
        set_timeout_d = (state_q == WAIT) && !accept_d && expire_d;
        set_overrun_d = ready && (state_q != IDLE);
    end

    // Scheduler FSM with registered outputs and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            enable_q      <= '0;
            acc_q         <= 14'sd0;
            idx_q         <= '0;
            cnt_q         <= '0;
            fx_start_q    <= 1'b0;
            fx_sample_q   <= 12'd0;
            fx_amount_q   <= 2'd0;
            fx_enable_q   <= 1'b0;
            mixed_q       <= 12'd0;
            mix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                samples_q[i] <= 12'd0;
                amounts_q[i] <= 2'd0;
            end
        end else begin
            fx_start_q    <= 1'b0;
            mix_valid_q   <= 1'b0;
            timeout_err_q <= set_timeout_d | (timeout_err_q & ~clear_flags);
            overrun_q     <= set_overrun_d | (overrun_q & ~clear_flags);
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            samples_q[i] <= ch_samples[i*12 +: 12];
                            amounts_q[i] <= ch_amount[i*2 +: 2];
                        end
                        enable_q    <= ch_enable;
                        acc_q       <= 14'sd0;
                        idx_q       <= '0;
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        fx_enable_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (enable_q[idx_q]) begin
                        fx_sample_q <= samples_q[idx_q];
                        fx_amount_q <= amounts_q[idx_q];
                        fx_start_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end else if (last_ch_d) begin
                        state_q <= MIX;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= ISSUE;
                    end
                end
                WAIT: begin
                    if (accept_d || expire_d) begin
                        if (accept_d) begin
                            acc_q <= acc_d;
                        end else begin
                            acc_q <= acc_q;
                        end
                        if (last_ch_d) begin
                            state_q <= MIX;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ISSUE;
                        end
                    end else begin
                        cnt_q   <= cnt_d;
                        state_q <= WAIT;
                    end
                end
                MIX: begin
                    mixed_q     <= clamp12(acc_q);
                    mix_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    fx_enable_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    fx_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign fx_start     = fx_start_q;
    assign fx_sample    = fx_sample_q;
    assign fx_amount    = fx_amount_q;
    assign fx_enable    = fx_enable_q;
    assign mixed_sample = mixed_q;
    assign mix_valid    = mix_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Directed bench for effect_scheduler: an echo effect unit responds to starts and
// scoreboard queues hold the expected issue order and mixed results.
module tb_effect_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic [47:0] ch_samples = 48'd0;
    logic [3:0]  ch_enable = 4'd0;
    logic [7:0]  ch_amount = 8'd0;
    logic        clear_flags = 1'b0;
    logic        fx_start;
    logic [11:0] fx_sample;
    logic [1:0]  fx_amount;
    logic        fx_enable;
    logic [11:0] fx_result;
    logic        fx_done = 1'b0;
    logic [11:0] mixed_sample;
    logic        mix_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int exp_smp_q[$];
    int exp_amt_q[$];
    int exp_mix_q[$];

    logic        done_hold = 1'b0;
    logic        drop_en = 1'b0;
    logic [11:0] drop_val = 12'd0;

    effect_scheduler #(.NUM_CH(4), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .ready(ready), .ch_samples(ch_samples),
        .ch_enable(ch_enable), .ch_amount(ch_amount), .clear_flags(clear_flags),
        .fx_start(fx_start), .fx_sample(fx_sample), .fx_amount(fx_amount),
        .fx_enable(fx_enable), .fx_result(fx_result), .fx_done(fx_done),
        .mixed_sample(mixed_sample), .mix_valid(mix_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Echo effect unit: result mirrors the presented sample, done one cycle after start.
    assign fx_result = fx_sample;
    always @(posedge clock) begin
        fx_done <= done_hold | (fx_start & ~(drop_en & (fx_sample == drop_val)));
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each start and each mix against the queued expectations.
    always @(negedge clock) begin
        if (!reset && fx_start) begin
            if (exp_smp_q.size() == 0) begin
                check("unexpected_fx_start", 1, 0);
            end else begin
                check("fx_sample", $signed(fx_sample), exp_smp_q.pop_front());
                check("fx_amount", int'(fx_amount), exp_amt_q.pop_front());
            end
        end
        if (!reset && mix_valid) begin
            if (exp_mix_q.size() == 0) begin
                check("unexpected_mix_valid", 1, 0);
            end else begin
                check("mixed_sample", $signed(mixed_sample), exp_mix_q.pop_front());
            end
        end
    end

    function automatic logic [47:0] pack(input int a, input int b, input int c, input int d);
        logic [11:0] w0, w1, w2, w3;
        w0 = 12'(a); w1 = 12'(b); w2 = 12'(c); w3 = 12'(d);
        return {w3, w2, w1, w0};
    endfunction

    // Queue expectations from an independent model, then pulse ready for one edge.
    task automatic start_set(input logic [47:0] s, input logic [3:0] en, input logic [7:0] amt,
                             input bit push_mix);
        int sum;
        logic [11:0] v;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                v = s[i*12 +: 12];
                exp_smp_q.push_back($signed(v));
                exp_amt_q.push_back(int'(amt[i*2 +: 2]));
                if (!(drop_en && v == drop_val) || done_hold) sum += $signed(v);
            end
        end
        if (sum > 2047) sum = 2047;
        if (sum < -2048) sum = -2048;
        if (push_mix) exp_mix_q.push_back(sum);
        @(negedge clock);
        ch_samples = s; ch_enable = en; ch_amount = amt; ready = 1'b1;
        @(posedge clock);
        #1 ready = 1'b0;
    endtask

    // Wait for mix_valid with a bound; edge 1 is the edge that sampled ready.
    task automatic wait_mix(input string tag, input int exp_edge);
        int n;
        bit seen;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clock);
            #1 n++;
            seen = mix_valid;
        end
        check({tag, "_mix_seen"}, int'(seen), 1);
        if (exp_edge > 0) check({tag, "_latency"}, n, exp_edge);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear_flags = 1'b1;
        @(posedge clock);
        #1 clear_flags = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", int'({fx_start, fx_enable, mix_valid, busy, timeout_err, overrun}), 0);
        check("reset_data", int'({mixed_sample, fx_sample, fx_amount}), 0);
        @(negedge clock);
        reset = 1'b0;

        // Basic ordered issue, mixed sum, and exact latency.
        start_set(pack(100, 200, 300, 400), 4'b1111, 8'h00, 1'b1);
        check("busy_after_ready", int'(busy), 1);
        check("fx_enable_after_ready", int'(fx_enable), 1);
        wait_mix("sum1000", 14);
        @(posedge clock); #1;
        check("busy_back_idle", int'(busy), 0);
        check("mix_valid_one_cycle", int'(mix_valid), 0);
        check("mixed_hold", $signed(mixed_sample), 1000);

        // Saturation both ways, with per-channel amounts routed through.
        start_set(pack(1500, 1500, 1500, 1500), 4'b1111, 8'b11100100, 1'b1);
        wait_mix("clamp_hi", 14);
        start_set(pack(-1500, -1500, -1500, -1500), 4'b1111, 8'b00011011, 1'b1);
        wait_mix("clamp_lo", 14);

        // Disabled channels are skipped in one edge each.
        start_set(pack(10, 20, 30, 40), 4'b0101, 8'h00, 1'b1);
        wait_mix("mask0101", 10);
        start_set(pack(-5, 6, 7, -8), 4'b0000, 8'h00, 1'b1);
        wait_mix("mask0000", 6);

        // Done held high: start edge must be ignored, accept on the following edge.
        done_hold = 1'b1;
        start_set(pack(5, -7, 9, 11), 4'b1111, 8'h55, 1'b1);
        wait_mix("done_held", 14);
        done_hold = 1'b0;
        repeat (2) @(posedge clock);

        // Channel 1 never answers: timeout, contributes 0, later channels still run.
        check("timeout_err_clean", int'(timeout_err), 0);
        drop_en = 1'b1; drop_val = 12'd200;
        start_set(pack(100, 200, 300, 400), 4'b1111, 8'h00, 1'b1);
        wait_mix("timeout", -1);
        drop_en = 1'b0;
        check("timeout_err_set", int'(timeout_err), 1);
        pulse_clear();
        check("timeout_err_cleared", int'(timeout_err), 0);

        // Ready while busy is dropped; in-flight result unaffected.
        start_set(pack(1, 2, 3, 4), 4'b1111, 8'h00, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        ch_samples = pack(999, 999, 999, 999); ready = 1'b1;
        @(posedge clock);
        #1 ready = 1'b0;
        check("overrun_set", int'(overrun), 1);
        @(negedge clock);
        ready = 1'b1; clear_flags = 1'b1;
        @(posedge clock);
        #1 ready = 1'b0; clear_flags = 1'b0;
        check("overrun_set_wins", int'(overrun), 1);
        wait_mix("overrun", -1);
        pulse_clear();
        check("overrun_cleared", int'(overrun), 0);

        // Reset mid-WAIT discards the transaction.
        drop_en = 1'b1; drop_val = 12'd77;
        start_set(pack(77, 1, 2, 3), 4'b0001, 8'h02, 1'b0);
        repeat (4) @(posedge clock);
        #1 check("stalled_busy", int'(busy), 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midwait_reset_outputs", int'({fx_start, fx_enable, mix_valid, busy, timeout_err, overrun}), 0);
        check("midwait_reset_data", int'({mixed_sample, fx_sample, fx_amount}), 0);
        @(negedge clock);
        reset = 1'b0; drop_en = 1'b0;
        repeat (25) @(posedge clock);
        #1 check("idle_after_reset", int'(busy), 0);

        // Scheduler still works after the interrupted transaction.
        start_set(pack(-100, 50, 0, 25), 4'b1111, 8'h00, 1'b1);
        wait_mix("post_reset", 14);
        repeat (2) @(posedge clock);
        check("starts_drained", exp_smp_q.size(), 0);
        check("mixes_drained", exp_mix_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
